lsm_sequencer: RTL and testbench

LSM_SEQUENCER -- requirements
Module: lsm_sequencer

---
 rtl/lsm_pkg.sv | 45 ++++
 rtl/lsm_prio_enc.sv | 23 ++
 rtl/lsm_sequencer.sv | 134 +++++++++++++
 tb/tb_lsm_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsm_pkg.sv
// Shared types and constants for the load/store-multiple sequencer:
// FSM states, operation modes, data-memory opcodes and special register indices.
package lsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_STM  = 2'b00,
    MODE_LDM  = 2'b01,
    MODE_PUSH = 2'b10,
    MODE_POP  = 2'b11
  } mode_e;

  localparam logic [6:0] OP_STM  = 7'b1100_000;
  localparam logic [6:0] OP_LDM  = 7'b1100_100;
  localparam logic [6:0] OP_PUSH = 7'b1011_010;
  localparam logic [6:0] OP_POP  = 7'b1011_110;

  localparam int         WORD_BYTES = 4;
  localparam int         REG_W      = 4;
  localparam logic [3:0] SP_IDX     = 4'd13;
  localparam logic [3:0] LR_IDX     = 4'd14;
  localparam logic [3:0] PC_IDX     = 4'd15;

  function automatic logic [6:0] mode_opcode(input mode_e m);
    case (m)
      MODE_STM:  return OP_STM;
      MODE_LDM:  return OP_LDM;
      MODE_PUSH: return OP_PUSH;
      default:   return OP_POP;
    endcase
  endfunction

  // List bit 8 names LR on a push and PC on a pop; all lower bits map directly.
  function automatic logic [3:0] map_reg(input mode_e m, input logic [3:0] idx);
    if (idx == 4'd8)
      return (m == MODE_POP) ? PC_IDX : LR_IDX;
    return idx;
  endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit index and population count of a register-list vector.
module lsm_prio_enc
  import lsm_pkg::*;
#(
  parameter int NLIST = 9
) (
  input  logic [NLIST-1:0] vec,
  output logic [REG_W-1:0] low_idx,
  output logic [REG_W-1:0] pop_cnt
);

  always_comb begin
    low_idx = '0;
    pop_cnt = '0;
    for (int i = NLIST - 1; i >= 0; i--) begin
      if (vec[i]) begin
        low_idx = REG_W'(i);
        pop_cnt = pop_cnt + REG_W'(1);
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Load/store-multiple and PUSH/POP beat sequencer (IDLE -> XFER -> DONE).
// Define LSM_WRITEBACK_EN to build the base-register writeback path.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NLIST  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [NLIST-1:0]  req_list,
  input  logic [2:0]        req_rn,
  input  logic [ADDR_W-1:0] req_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [6:0]        mem_opcode,
  output logic [REG_W-1:0]  st_idx,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_widx,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_idx,
  output logic [ADDR_W-1:0] wb_val
);

  state_e            state_q, state_d;
  mode_e             req_mode_e, mode_q;
  logic [NLIST-1:0]  eff_list, work_q, enc_in;
  logic [ADDR_W-1:0] addr_q, span, start_addr;
  logic [REG_W-1:0]  enc_idx, enc_cnt;
  logic              accept, in_xfer, is_store, rf_we_p1;
  logic [REG_W-1:0]  rf_widx_p1;

  assign req_mode_e = mode_e'(req_mode);

  always_comb begin
    eff_list = req_list;
    if (req_mode_e == MODE_STM || req_mode_e == MODE_LDM)
      eff_list[NLIST-1] = 1'b0;
  end

  // One encoder serves both the accept-time popcount and the per-beat pick.
  assign enc_in = (state_q == ST_IDLE) ? eff_list : work_q;

  lsm_prio_enc #(.NLIST(NLIST)) u_enc (
    .vec     (enc_in),
    .low_idx (enc_idx),
    .pop_cnt (enc_cnt)
  );

  assign span       = ADDR_W'(enc_cnt) * ADDR_W'(WORD_BYTES);
  assign start_addr = (req_mode_e == MODE_PUSH) ? req_base - span : req_base;
  assign in_xfer    = (state_q == ST_XFER);
  assign is_store   = (mode_q == MODE_STM) || (mode_q == MODE_PUSH);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (enc_cnt == '0) ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: if (enc_cnt == REG_W'(1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rf_we_p1   <= 1'b0;
      rf_widx_p1 <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_p1   <= in_xfer && !is_store;
      rf_widx_p1 <= (in_xfer && !is_store) ? map_reg(mode_q, enc_idx) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mode_q <= req_mode_e;
      work_q <= eff_list;
      addr_q <= start_addr;
    end else if (in_xfer) begin
      work_q <= work_q & (work_q - NLIST'(1));
      addr_q <= addr_q + ADDR_W'(WORD_BYTES);
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign mem_addr     = in_xfer ? addr_q : '0;
  assign mem_opcode   = in_xfer ? mode_opcode(mode_q) : 7'd0;
  assign mem_write_en = in_xfer && is_store;
  assign st_idx       = (in_xfer && is_store) ? map_reg(mode_q, enc_idx) : '0;
  assign rf_we        = rf_we_p1;
  assign rf_widx      = rf_widx_p1;

`ifdef LSM_WRITEBACK_EN
  logic              wb_en_q;
  logic [REG_W-1:0]  wb_idx_q;
  logic [ADDR_W-1:0] wb_val_q;

  // An LDM that reloads its own base keeps the loaded value instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      wb_en_q  <= (enc_cnt != '0) && !(req_mode_e == MODE_LDM && req_list[req_rn]);
      wb_idx_q <= (req_mode_e == MODE_PUSH || req_mode_e == MODE_POP) ? SP_IDX : {1'b0, req_rn};
      wb_val_q <= (req_mode_e == MODE_PUSH) ? req_base - span : req_base + span;
    end
  end

  assign wb_en  = done && wb_en_q;
  assign wb_idx = done ? wb_idx_q : '0;
  assign wb_val = done ? wb_val_q : '0;
`else
  logic unused_rn;
  assign unused_rn = ^req_rn;
  assign wb_en     = 1'b0;
  assign wb_idx    = '0;
  assign wb_val    = '0;
`endif

endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: directed requests queue expected beats,
// writebacks and completions; a negedge monitor pops and compares them.
module tb_lsm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_mode = 2'b00;
  logic [8:0]  req_list = 9'h000;
  logic [2:0]  req_rn = 3'd0;
  logic [31:0] req_base = 32'h0;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [6:0]  mem_opcode;
  logic [3:0]  st_idx;
  logic        rf_we;
  logic [3:0]  rf_widx;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic [31:0] wb_val;

  lsm_sequencer #(.ADDR_W(32), .NLIST(9)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_list(req_list), .req_rn(req_rn), .req_base(req_base),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_opcode(mem_opcode),
    .st_idx(st_idx), .rf_we(rf_we), .rf_widx(rf_widx), .busy(busy), .done(done),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_val(wb_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct { int c; logic [31:0] addr; logic we; logic [3:0] idx; logic [6:0] op; } beat_t;
  typedef struct { int c; logic [3:0] idx; } rf_t;
  typedef struct { int c; logic en; logic [3:0] idx; logic [31:0] val; } done_t;

  beat_t beat_q[$];
  rf_t   rf_q[$];
  done_t done_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_evt(input string nm, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got unexpected event value %h, expected no event (cycle %0d)", nm, act, cyc);
  endtask

  task automatic exp_beat(input int c, input logic [31:0] a, input logic we,
                          input logic [3:0] idx, input logic [6:0] op);
    beat_t b;
    b.c = c; b.addr = a; b.we = we; b.idx = idx; b.op = op;
    beat_q.push_back(b);
  endtask

  task automatic exp_rf(input int c, input logic [3:0] idx);
    rf_t r;
    r.c = c; r.idx = idx;
    rf_q.push_back(r);
  endtask

  task automatic exp_done(input int c, input logic en, input logic [3:0] idx, input logic [31:0] val);
    done_t d;
    d.c = c;
`ifdef LSM_WRITEBACK_EN
    d.en = en; d.idx = en ? idx : 4'd0; d.val = en ? val : 32'h0;
`else
    d.en = 1'b0; d.idx = 4'd0; d.val = 32'h0;
`endif
    done_q.push_back(d);
  endtask

  always @(negedge clk) begin
    beat_t b;
    rf_t   r;
    done_t d;
    if (mem_opcode != 7'd0 || mem_write_en) begin
      if (beat_q.size() == 0) fail_evt("beat_unexpected", mem_addr);
      else begin
        b = beat_q.pop_front();
        chk("beat_cycle", cyc, b.c);
        chk("beat_addr", mem_addr, b.addr);
        chk("beat_we", {31'd0, mem_write_en}, {31'd0, b.we});
        chk("beat_st_idx", {28'd0, st_idx}, {28'd0, b.idx});
        chk("beat_opcode", {25'd0, mem_opcode}, {25'd0, b.op});
      end
    end
    if (rf_we || rf_widx != 4'd0) begin
      if (rf_q.size() == 0) fail_evt("rf_unexpected", {28'd0, rf_widx});
      else begin
        r = rf_q.pop_front();
        chk("rf_cycle", cyc, r.c);
        chk("rf_we", {31'd0, rf_we}, 32'd1);
        chk("rf_widx", {28'd0, rf_widx}, {28'd0, r.idx});
      end
    end
    if (done || wb_en) begin
      if (done_q.size() == 0) fail_evt("done_unexpected", {31'd0, done});
      else begin
        d = done_q.pop_front();
        chk("done_cycle", cyc, d.c);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("wb_en", {31'd0, wb_en}, {31'd0, d.en});
        chk("wb_idx", {28'd0, wb_idx}, {28'd0, d.idx});
        chk("wb_val", wb_val, d.val);
      end
    end
  end

  task automatic drive(input logic [1:0] m, input logic [8:0] l, input logic [2:0] rn,
                       input logic [31:0] b);
    req_valid = 1'b1; req_mode = m; req_list = l; req_rn = rn; req_base = b;
  endtask

  // Returns the cycle index seen by the monitor in the cycle right after the accept edge.
  task automatic wait_accept(output int e);
    bit got;
    got = 1'b0;
    e = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    if (got) begin
      @(posedge clk);
      #1;
      e = cyc;
    end else begin
      n_total++;
      $display("FAIL accept_timeout: req_ready never rose, expected acceptance within 50 cycles");
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int e, e2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_outputs", {24'd0, mem_write_en, rf_we, done, wb_en, mem_opcode[3:0]}, 32'd0);
    gap(1);

    // PUSH {r0, r1, LR} from 0x100
    drive(2'b10, 9'h103, 3'd0, 32'h100);
    wait_accept(e); req_valid = 1'b0;
    exp_beat(e,     32'hF4, 1'b1, 4'd0,  7'b1011010);
    exp_beat(e + 1, 32'hF8, 1'b1, 4'd1,  7'b1011010);
    exp_beat(e + 2, 32'hFC, 1'b1, 4'd14, 7'b1011010);
    exp_done(e + 3, 1'b1, 4'd13, 32'hF4);
    @(negedge clk);
    chk("busy_in_xfer", {31'd0, busy}, 32'd1);
    chk("ready_in_xfer", {31'd0, req_ready}, 32'd0);
    gap(5);

    // POP {r7, PC} from 0xF4
    drive(2'b11, 9'h180, 3'd0, 32'hF4);
    wait_accept(e); req_valid = 1'b0;
    exp_beat(e,     32'hF4, 1'b0, 4'd0, 7'b1011110);
    exp_beat(e + 1, 32'hF8, 1'b0, 4'd0, 7'b1011110);
    exp_rf(e + 1, 4'd7);
    exp_rf(e + 2, 4'd15);
    exp_done(e + 2, 1'b1, 4'd13, 32'hFC);
    gap(5);

    // LDM r2!, {r2, r3} from 0x200: base is in the list, so no writeback
    drive(2'b01, 9'h00C, 3'd2, 32'h200);
    wait_accept(e); req_valid = 1'b0;
    exp_beat(e,     32'h200, 1'b0, 4'd0, 7'b1100100);
    exp_beat(e + 1, 32'h204, 1'b0, 4'd0, 7'b1100100);
    exp_rf(e + 1, 4'd2);
    exp_rf(e + 2, 4'd3);
    exp_done(e + 2, 1'b0, 4'd0, 32'h0);
    gap(5);

    // STM r1!, {r0, r2} from 0x300; bit 8 must be ignored for STM
    drive(2'b00, 9'h105, 3'd1, 32'h300);
    wait_accept(e); req_valid = 1'b0;
    exp_beat(e,     32'h300, 1'b1, 4'd0, 7'b1100000);
    exp_beat(e + 1, 32'h304, 1'b1, 4'd2, 7'b1100000);
    exp_done(e + 2, 1'b1, 4'd1, 32'h308);
    gap(5);

    // STM with empty list: no beats, done one cycle after accept
    drive(2'b00, 9'h000, 3'd1, 32'h400);
    wait_accept(e); req_valid = 1'b0;
    exp_done(e, 1'b0, 4'd0, 32'h0);
    gap(4);

    // PUSH {r0} from address 0 wraps silently
    drive(2'b10, 9'h001, 3'd0, 32'h0);
    wait_accept(e); req_valid = 1'b0;
    exp_beat(e, 32'hFFFF_FFFC, 1'b1, 4'd0, 7'b1011010);
    exp_done(e + 1, 1'b1, 4'd13, 32'hFFFF_FFFC);
    gap(4);

    // STM {r0-r7} from 0x40 with reset during the third beat
    drive(2'b00, 9'h0FF, 3'd5, 32'h40);
    wait_accept(e); req_valid = 1'b0;
    exp_beat(e,     32'h40, 1'b1, 4'd0, 7'b1100000);
    exp_beat(e + 1, 32'h44, 1'b1, 4'd1, 7'b1100000);
    exp_beat(e + 2, 32'h48, 1'b1, 4'd2, 7'b1100000);
    gap(2);
    rst = 1'b1;
    gap(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    gap(10);

    // Two PUSHes with req_valid held high across both
    drive(2'b10, 9'h003, 3'd0, 32'h500);
    wait_accept(e);
    exp_beat(e,     32'h4F8, 1'b1, 4'd0, 7'b1011010);
    exp_beat(e + 1, 32'h4FC, 1'b1, 4'd1, 7'b1011010);
    exp_done(e + 2, 1'b1, 4'd13, 32'h4F8);
    drive(2'b10, 9'h100, 3'd0, 32'h600);
    wait_accept(e2); req_valid = 1'b0;
    chk("b2b_accept_cycle", e2, e + 4);
    exp_beat(e + 4, 32'h5FC, 1'b1, 4'd14, 7'b1011010);
    exp_done(e + 5, 1'b1, 4'd13, 32'h5FC);
    gap(8);

    chk("beat_q_drained", beat_q.size(), 32'd0);
    chk("rf_q_drained", rf_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
